// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the floating-point multiplier issuer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_mul_pkg;

  localparam int FP_WIDTH = 32;

  // Canonical quiet NaN returned when the multiplier never answers.
  localparam logic [FP_WIDTH-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Result register contents: the product and whether it is a timeout stand-in.
  typedef struct packed {
    logic [FP_WIDTH-1:0] result;
    logic                timeout;
  } res_t;

endpackage

// File: rtl/fp_wait_timer.sv
// Wait-cycle counter that flags when an operation has waited TIMEOUT cycles.
// Latency: expired is combinational on the count; clear/enable take effect next cycle.
// Backpressure: none; saturates at TIMEOUT-1 so a stalled owner never sees it wrap.
//
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   clear         synchronous return of the count to 0 (wins over enable)
//   enable        advance the count by one
//   expired       count == TIMEOUT-1
module fp_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  assign expired = (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_issuer.sv
// Issues operand pairs to a start/done multiplier and returns its product on a stream.
// Latency: 3+L cycles in-to-out for a done L cycles into WAIT; TIMEOUT+2 on timeout.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready.
//
// Ports:
//   clk, rst                         clock and asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b      operand-pair stream
//   out_valid/out_ready              result stream handshake
//   out_result/out_timeout           product, or qNaN with timeout flag
//   mul_start/mul_a/mul_b            request side of the multiplier
//   mul_result/mul_done              completion side of the multiplier
//   busy                             an operation is in flight
module fp_mul_issuer
  import fp_mul_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_WIDTH-1:0] in_a,
  input  logic [FP_WIDTH-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_WIDTH-1:0] out_result,
  output logic                out_timeout,
  output logic                mul_start,
  output logic [FP_WIDTH-1:0] mul_a,
  output logic [FP_WIDTH-1:0] mul_b,
  input  logic [FP_WIDTH-1:0] mul_result,
  input  logic                mul_done,
  output logic                busy
);

  state_t state;
  state_t state_nxt;
  res_t   res_q;
  logic   expired;

  // The count is cleared in START so the first WAIT cycle reads 0 and the
  // last permitted WAIT cycle is TIMEOUT-1.
  fp_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == START),
    .enable  (state == WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (mul_done || expired) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are only ever loaded on the IDLE accept, so they stay put for
  // the whole START/WAIT window the multiplier may be sampling them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (state == IDLE && in_valid) begin
      mul_a <= in_a;
      mul_b <= in_b;
    end
  end

  // mul_done is checked first so a completion on the final WAIT cycle
  // returns the real product rather than the timeout stand-in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
    end else if (state == WAIT) begin
      if (mul_done) begin
        res_q.result  <= mul_result;
        res_q.timeout <= 1'b0;
      end else if (expired) begin
        res_q.result  <= FP_QNAN;
        res_q.timeout <= 1'b1;
      end
    end
  end

  // All handshake outputs decode from state alone; no stream input feeds
  // through to a stream output in the same cycle.
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == HOLD);
  assign mul_start   = (state == START);
  assign busy        = (state != IDLE);
  assign out_result  = res_q.result;
  assign out_timeout = res_q.timeout;

endmodule

// File: doc/fp_mul_issuer.md
# fp_mul_issuer

Hardware initiator for the sequential single-precision floating-point multiplier's start/done protocol. It accepts operand pairs on a valid/ready stream and drives `mul_start`/`mul_a`/`mul_b` to the multiplier. It captures `mul_result` on `mul_done` and returns it on a valid/ready result stream, replacing the hand-driven stimulus used in simulation. A watchdog converts a hung multiplier into a flagged qNaN result so upstream logic never deadlocks.

## Interface
- `TIMEOUT`, 64: maximum WAIT cycles before abandoning an operation (≥2).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  issuer can accept an operand pair.
- `in_a`, `in_b`  in  32  IEEE-754 single operands.
- `out_valid`  out  1  result pending.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  32  product, or qNaN 32'h7FC00000 on timeout.
- `out_timeout`  out  1  qualifies `out_result` as timeout (valid with `out_valid`).
- `mul_start`  out  1  one-cycle start pulse to multiplier.
- `mul_a`, `mul_b`  out  32  operands to multiplier, held stable from START through end of WAIT.
- `mul_result`  in  32  multiplier product, sampled only when `mul_done`=1.
- `mul_done`  in  1  one-cycle completion pulse from multiplier.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, START, WAIT, HOLD.
- IDLE: `in_ready`=1. On `in_valid`: register `in_a`/`in_b` into `mul_a`/`mul_b`, go START.
- START: `mul_start`=1 for exactly this cycle. Clear wait counter. Go WAIT.
- WAIT: counter increments each cycle.
  - `mul_done`=1: register `mul_result`, clear `out_timeout`, go HOLD.
  - Else, counter = TIMEOUT-1: load 32'h7FC00000, set `out_timeout`, go HOLD.
  - `mul_done` and timeout in the same cycle: done wins.
- HOLD: `out_valid`=1. `out_result`/`out_timeout` stable until `out_ready`=1, then go IDLE.
- `mul_done` outside WAIT is ignored, including a late done after a timeout.
- `mul_a`/`mul_b` are not changed outside the IDLE capture.
- `in_ready` depends only on state, never combinationally on `in_valid`.
- `out_valid` depends only on state, never on `out_ready`.
- Reset at any time, including mid-WAIT or mid-HOLD: immediate return to IDLE, pending result discarded.
- Reset values:
  - state IDLE, so `in_ready`=1 and `busy`=0.
  - `mul_start`=0, `mul_a`=`mul_b`=0.
  - `out_valid`=0, `out_result`=0, `out_timeout`=0, counter 0.

## Timing
- Cycle 0: in handshake (IDLE, `in_valid`=1).
- Cycle 1: `mul_start`=1.
- Cycle ≥2: WAIT.
- A multiplier asserting done at cycle 2+L (L≥0) gives `out_valid` at cycle 3+L.
- Minimum in-to-out latency is 3 cycles.
- Timeout: `out_valid` with `out_timeout` exactly TIMEOUT+2 cycles after the in handshake.
- An `out_ready` handshake in cycle n gives `in_ready`=1 in cycle n+1. One operation in flight, no overlap.
- Peak throughput: one operation per 4+L cycles.

## Structure
- Shared package `fp_mul_pkg`:
  - state enum (IDLE, START, WAIT, HOLD; 2-bit encoding).
  - `FP_QNAN` = 32'h7FC00000.
  - `FP_WIDTH` = 32.
- Sub-module `fp_wait_timer`:
  - `$clog2(TIMEOUT)`-bit counter with `clear`, `enable`, `expired` (= count == TIMEOUT-1).
  - Same clk/rst convention.
- FSM, operand registers and result registers live in `fp_mul_issuer`.

## Test plan
Each scenario uses a behavioural multiplier model with programmable done latency L.

- **Basic:** in_a=3F800000, in_b=40000000, L=3, `out_ready`=1.
  - `mul_start` pulses once at cycle 1.
  - `out_valid` at cycle 6 with `out_result`=40000000, `out_timeout`=0.
- **Backpressure:** 40400000×40800000, L=0, `out_ready` held 0 for 5 cycles.
  - `out_result`=41400000 stays stable and `in_ready`=0 throughout.
  - Released one cycle after `out_ready` rises.
- **Timeout:** TIMEOUT=8, model never asserts done.
  - `out_valid` at cycle 10 with 7FC00000, `out_timeout`=1.
  - A late `mul_done` at cycle 12 is ignored.
- **Tie:** `mul_done` on the final WAIT cycle (TIMEOUT-1).
  - Real result is returned, `out_timeout`=0.
- **Reset mid-WAIT:** `rst`=0 at cycle 3.
  - All outputs take reset values asynchronously; `in_ready`=1 after release.
  - The next op (BF800000×3F800000) returns BF800000.
- **Back-to-back:** 5 random pairs with `in_valid` held high.
  - Each pair is issued exactly once, in order.
  - Results match the model, with no `mul_start` during WAIT or HOLD.
